// File: rtl/ram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader_pkg
// Description : Shared defaults and FSM state encoding for the RAM loader.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_loader_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 8;
    localparam int c_DEFAULT_RAM_LENGTH = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader_if
// Description : Host-side load request and byte handshake for the RAM loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_loader_if
    import ram_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = c_DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = $clog2(c_DEFAULT_RAM_LENGTH)
);

    logic                   i_START;
    logic [ADDRESS_WIDTH:0] i_COUNT;
    logic                   i_ABORT;
    logic [DATA_WIDTH-1:0]  i_DATA;
    logic                   i_VALID;
    logic                   o_READY;

    modport master (
        output i_START,
        output i_COUNT,
        output i_ABORT,
        output i_DATA,
        output i_VALID,
        input  o_READY
    );

    modport slave (
        input  i_START,
        input  i_COUNT,
        input  i_ABORT,
        input  i_DATA,
        input  i_VALID,
        output o_READY
    );

endinterface
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader
// Description : Loads host bytes into RAM over the shared bus, two cycles/byte.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = c_DEFAULT_DATA_WIDTH,
    parameter int RAM_LENGTH    = c_DEFAULT_RAM_LENGTH,
    parameter int ADDRESS_WIDTH = $clog2(RAM_LENGTH)
) (
    input  wire logic                     i_CLOCK,
    input  wire logic                     i_RESET_N,
    ram_loader_if.slave                   host,
    inout  wire       [DATA_WIDTH-1:0]    BUS,
    output logic      [ADDRESS_WIDTH-1:0] o_MAR_DATA,
    output logic                          o_RAM_READ_BUS,
    output logic                          o_BUSY,
    output logic                          o_DONE
);

    localparam logic [ADDRESS_WIDTH:0] c_RAM_LENGTH = (ADDRESS_WIDTH+1)'(RAM_LENGTH);
    localparam logic [ADDRESS_WIDTH:0] c_ONE_WIDE   = (ADDRESS_WIDTH+1)'(1);
    localparam logic [ADDRESS_WIDTH-1:0] c_ONE      = ADDRESS_WIDTH'(1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [ADDRESS_WIDTH:0]   r_count;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [ADDRESS_WIDTH:0]   w_eff_count;
    logic [ADDRESS_WIDTH:0]   w_bytes_written;
    logic                     w_last;
    logic                     w_handshake;

    // Out-of-range counts load the whole RAM, so the address never wraps.
    always_comb begin
        w_eff_count = host.i_COUNT;
        if (host.i_COUNT == '0 || host.i_COUNT > c_RAM_LENGTH) begin
            w_eff_count = c_RAM_LENGTH;
        end
    end

    assign w_bytes_written = {1'b0, r_addr} + c_ONE_WIDE;
    assign w_last          = (w_bytes_written == r_count);
    assign w_handshake     = (r_state == S_WAIT) && host.i_VALID && !host.i_ABORT;

    always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        host.o_READY   = 1'b0;
        o_BUSY         = 1'b1;
        o_DONE         = 1'b0;
        o_RAM_READ_BUS = 1'b0;
        o_MAR_DATA     = r_addr;
        case (r_state)
            S_IDLE: begin
                o_BUSY     = 1'b0;
                o_MAR_DATA = '0;
                if (host.i_START) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                host.o_READY = 1'b1;
                // Abort wins over a handshake in the same cycle.
                if (host.i_ABORT) begin
                    w_next_state = S_IDLE;
                end else if (host.i_VALID) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                o_RAM_READ_BUS = 1'b1;
                if (host.i_ABORT) begin
                    w_next_state = S_IDLE;
                end else if (w_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_DONE: begin
                o_DONE       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            r_count <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            if (r_state == S_IDLE && host.i_START) begin
                r_count <= w_eff_count;
                r_addr  <= '0;
            end
            if (w_handshake) begin
                r_data <= host.i_DATA;
            end
            if (r_state == S_WRITE && w_next_state == S_WAIT) begin
                r_addr <= r_addr + c_ONE;
            end
        end
    end

    assign BUS = (r_state == S_WRITE) ? r_data : {DATA_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of bus and data bytes.
REQ-002 Parameter RAM_LENGTH, default 16, number of RAM locations.
REQ-003 Parameter ADDRESS_WIDTH, default $clog2(RAM_LENGTH), width of RAM address.
REQ-004 i_CLOCK  in  1  sole clock; all state updates on rising edge.
REQ-005 i_RESET_N  in  1  asynchronous, active-low reset.
REQ-006 i_START  in  1  request a load session, sampled in IDLE only.
REQ-007 i_COUNT  in  ADDRESS_WIDTH+1  bytes to load; 0 or >RAM_LENGTH means RAM_LENGTH.
REQ-008 i_ABORT  in  1  terminate the session early.
REQ-009 i_DATA  in  DATA_WIDTH  byte from host.
REQ-010 i_VALID  in  1  i_DATA valid.
REQ-011 o_READY  out  1  loader accepts i_DATA this cycle.
REQ-012 BUS  inout  DATA_WIDTH  shared system bus; driven only during WRITE, else high-Z.
REQ-013 o_MAR_DATA  out  ADDRESS_WIDTH  RAM address during the session.
REQ-014 o_RAM_READ_BUS  out  1  RAM latches BUS into location o_MAR_DATA at the next rising edge.
REQ-015 o_BUSY  out  1  loader owns bus and RAM address; CPU held off.
REQ-016 o_DONE  out  1  one-cycle pulse on normal completion.

Function
REQ-017 FSM states IDLE, WAIT, WRITE, DONE.
REQ-018 IDLE: o_BUSY=0, o_READY=0, BUS high-Z; i_START=1 -> latch effective count, address := 0, go to WAIT.
REQ-019 WAIT: o_BUSY=1, o_READY=1; i_VALID&o_READY at edge -> capture i_DATA, go to WRITE.
REQ-020 WRITE lasts exactly one cycle: BUS=captured byte, o_RAM_READ_BUS=1, o_READY=0, o_MAR_DATA=current address.
REQ-021 WRITE exit: if bytes written equals effective count -> DONE, else address+1 and WAIT.
REQ-022 DONE: o_DONE=1, o_BUSY=1, bus released, one cycle, then IDLE.
REQ-023 Throughput one byte per two cycles; first byte can be accepted the cycle after i_START is sampled.
REQ-024 Address never exceeds RAM_LENGTH-1; no wrap-around, since count is clamped.
REQ-025 i_START outside IDLE ignored; i_VALID outside WAIT ignored and not consumed.
REQ-026 i_ABORT in WAIT -> IDLE next edge, no DONE pulse; abort has priority over a simultaneous handshake.
REQ-027 i_ABORT in WRITE -> the write completes, then IDLE without DONE.
REQ-028 o_MAR_DATA=0 in IDLE; o_RAM_READ_BUS=1 only in WRITE.

Reset
REQ-029 i_RESET_N low forces IDLE asynchronously; o_READY, o_RAM_READ_BUS, o_BUSY, o_DONE=0; o_MAR_DATA=0; BUS high-Z immediately.
REQ-030 Reset mid-session abandons the session; RAM locations already written keep their contents.
REQ-031 Captured byte and count registers reset to 0.

Structure
REQ-032 State encoding and default parameter values reside in the shared xdn package/header.
REQ-033 Single module with no sub-module; address/byte counters are inline.

Verification
REQ-034 i_COUNT=3, bytes 0xA1,0xB2,0xC3 offered back-to-back -> RAM[0..2]=A1,B2,C3; o_DONE pulses once, 7 cycles after i_START.
REQ-035 i_COUNT=0 -> 16 bytes accepted, last write at address 15; DONE; no write to address 0 after the 16th byte.
REQ-036 Host i_VALID gaps of 3 cycles -> BUS high-Z and o_RAM_READ_BUS=0 throughout the gaps; data correct.
REQ-037 i_ABORT asserted in WAIT after 2 of 5 bytes -> IDLE; RAM[0..1] written; RAM[2] unchanged; no o_DONE.
REQ-038 i_RESET_N pulsed low during WRITE -> BUS high-Z and o_BUSY=0 without waiting for a clock edge; next i_START restarts at address 0.
REQ-039 i_START and i_VALID pulsed while in WAIT -> no restart; only handshaked bytes are written.
